// File: rtl/fc_link_mon_pkg.sv
// fc_link_monitor shared types, CSR map and xcvr status-word layout.
// FC_LINK_MON_UNKNOWN_PRIM_EN adds the unknown-primitive poll and CSRs 5/6.
package fc_link_mon_pkg;

  typedef enum logic [1:0] {
    LS_DOWN    = 2'd0,
    LS_SYNCING = 2'd1,
    LS_UP      = 2'd2
  } link_state_t;

`ifdef FC_LINK_MON_UNKNOWN_PRIM_EN
  typedef enum logic [1:0] {
    PS_WAIT       = 2'd0,
    PS_RD_STATUS  = 2'd1,
    PS_EVAL       = 2'd2,
    PS_RD_UNKNOWN = 2'd3
  } poll_state_t;
  localparam int STICKY_W = 4;
`else
  typedef enum logic [1:0] {
    PS_WAIT      = 2'd0,
    PS_RD_STATUS = 2'd1,
    PS_EVAL      = 2'd2
  } poll_state_t;
  localparam int STICKY_W = 3;
`endif

  localparam logic [2:0] CSR_STATUS   = 3'd0;
  localparam logic [2:0] CSR_LOS      = 3'd1;
  localparam logic [2:0] CSR_CERR     = 3'd2;
  localparam logic [2:0] CSR_STICKY   = 3'd3;
  localparam logic [2:0] CSR_CTRL     = 3'd4;
  localparam logic [2:0] CSR_UNK_WORD = 3'd5;
  localparam logic [2:0] CSR_UNK_CNT  = 3'd6;

  localparam logic [9:0] ADDR_STATUS  = 10'h000;
  localparam logic [9:0] ADDR_UNKNOWN = 10'h001;

  localparam int SYNC_LSB = 0;
  localparam int PAT_LSB  = 4;
  localparam int ERR_LSB  = 8;
  localparam int DISP_LSB = 12;
  localparam int PLL_BIT  = 16;

  localparam int STK_LOS  = 0;
  localparam int STK_UP   = 1;
  localparam int STK_CERR = 2;
  localparam int STK_UNK  = 3;

  function automatic logic poll_good(input logic [16:0] w);
    return (w[SYNC_LSB +: 4] == 4'hF) && w[PLL_BIT];
  endfunction

endpackage

// File: rtl/fc_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear dominates a simultaneous increment.
module fc_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             mgmt_clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise count up and stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge mgmt_clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/fc_link_monitor.sv
// Polls the FC xcvr status word, debounces link state, counts events.
// FC_LINK_MON_UNKNOWN_PRIM_EN enables the extra unknown-primitive read.
module fc_link_monitor
  import fc_link_mon_pkg::*;
#(
  parameter int POLL_INTERVAL   = 1024,
  parameter int SYNC_UP_COUNT   = 8,
  parameter int SYNC_DOWN_COUNT = 2,
  parameter int CNT_W           = 16
) (
  input  logic        mgmt_clk,
  input  logic        reset,
  output logic [9:0]  xm_address,
  output logic        xm_read,
  input  logic        xm_waitrequest,
  input  logic [31:0] xm_readdata,
  input  logic [2:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        link_up,
  output logic        irq
);

  localparam int TW = $clog2(POLL_INTERVAL);
  localparam logic [TW-1:0] TMR_RELOAD = TW'(POLL_INTERVAL - 1);
  localparam logic [7:0] UP_N = 8'(SYNC_UP_COUNT);
  localparam logic [7:0] DN_N = 8'(SYNC_DOWN_COUNT);

  poll_state_t ps_q, ps_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [16:0] stat_q, stat_d;
  logic eval;

  link_state_t ls_q, ls_d;
  logic [7:0] good_q, good_d;
  logic [7:0] bad_q, bad_d;

  logic [STICKY_W-1:0] sticky_q, sticky_d;
  logic [STICKY_W-1:0] sticky_set, sticky_w1c;
  logic [STICKY_W-1:0] mask_q, mask_d;
  logic poll_en_q, poll_en_d;

  logic los_inc, cerr_inc;
  logic wr_los, wr_cerr, wr_sticky, wr_ctrl;
  logic [CNT_W-1:0] los_val, cerr_val;
  logic good_poll, err_poll;
  logic [31:0] rdata;

`ifdef FC_LINK_MON_UNKNOWN_PRIM_EN
  logic [31:0] unk_word_q, unk_word_d;
  logic unk_new;
  logic wr_unk;
  logic [CNT_W-1:0] unk_val;
`endif

  logic unused_bits;
  assign unused_bits = ^{csr_writedata[31:8+STICKY_W],
                         csr_writedata[7:1],
                         xm_readdata[31:17]};

  assign wr_los    = csr_write && (csr_address == CSR_LOS);
  assign wr_cerr   = csr_write && (csr_address == CSR_CERR);
  assign wr_sticky = csr_write && (csr_address == CSR_STICKY);
  assign wr_ctrl   = csr_write && (csr_address == CSR_CTRL);

  // poll sequencer: interval timer, Avalon read handshake, capture
  always_comb begin
    ps_d   = ps_q;
    tmr_d  = tmr_q;
    stat_d = stat_q;
    eval   = 1'b0;
`ifdef FC_LINK_MON_UNKNOWN_PRIM_EN
    unk_word_d = unk_word_q;
    unk_new    = 1'b0;
`endif
    case (ps_q)
      PS_WAIT: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (poll_en_q) begin
          ps_d = PS_RD_STATUS;
        end
      end
      PS_RD_STATUS: begin
        if (!xm_waitrequest) begin
          stat_d = xm_readdata[16:0];
`ifdef FC_LINK_MON_UNKNOWN_PRIM_EN
          ps_d = PS_RD_UNKNOWN;
`else
          ps_d = PS_EVAL;
`endif
        end
      end
`ifdef FC_LINK_MON_UNKNOWN_PRIM_EN
      PS_RD_UNKNOWN: begin
        if (!xm_waitrequest) begin
          ps_d = PS_EVAL;
          if (xm_readdata != unk_word_q) begin
            unk_new    = 1'b1;
            unk_word_d = xm_readdata;
          end
        end
      end
`endif
      PS_EVAL: begin
        eval  = 1'b1;
        ps_d  = PS_WAIT;
        tmr_d = TMR_RELOAD;
      end
      default: ps_d = PS_WAIT;
    endcase
  end

  assign good_poll = poll_good(stat_q);
  assign err_poll  = |(stat_q[ERR_LSB +: 4] | stat_q[DISP_LSB +: 4]);

  // link debounce FSM and event detection, advanced once per poll
  always_comb begin
    ls_d       = ls_q;
    good_d     = good_q;
    bad_d      = bad_q;
    los_inc    = 1'b0;
    cerr_inc   = 1'b0;
    sticky_set = '0;
    if (eval) begin
      if (err_poll && (ls_q != LS_DOWN)) begin
        cerr_inc             = 1'b1;
        sticky_set[STK_CERR] = 1'b1;
      end
      case (ls_q)
        LS_DOWN: begin
          if (good_poll) begin
            good_d = 8'd1;
            if (UP_N == 8'd1) begin
              ls_d               = LS_UP;
              bad_d              = '0;
              sticky_set[STK_UP] = 1'b1;
            end else begin
              ls_d = LS_SYNCING;
            end
          end
        end
        LS_SYNCING: begin
          if (good_poll) begin
            good_d = good_q + 8'd1;
            if (good_d == UP_N) begin
              ls_d               = LS_UP;
              bad_d              = '0;
              sticky_set[STK_UP] = 1'b1;
            end
          end else begin
            ls_d = LS_DOWN;
          end
        end
        LS_UP: begin
          if (good_poll) begin
            bad_d = '0;
          end else begin
            bad_d = bad_q + 8'd1;
            if (bad_d == DN_N) begin
              ls_d                = LS_DOWN;
              bad_d               = '0;
              los_inc             = 1'b1;
              sticky_set[STK_LOS] = 1'b1;
            end
          end
        end
        default: ls_d = LS_DOWN;
      endcase
    end
`ifdef FC_LINK_MON_UNKNOWN_PRIM_EN
    sticky_set[STK_UNK] = unk_new;
`endif
  end

  // sticky W1C (hardware set wins) and control register
  always_comb begin
    sticky_w1c = wr_sticky ? csr_writedata[STICKY_W-1:0] : '0;
    sticky_d   = (sticky_q & ~sticky_w1c) | sticky_set;
    poll_en_d  = poll_en_q;
    mask_d     = mask_q;
    if (wr_ctrl) begin
      poll_en_d = csr_writedata[0];
      mask_d    = csr_writedata[8 +: STICKY_W];
    end
  end

  // state registers
  always_ff @(posedge mgmt_clk) begin
    if (reset) begin
      ps_q      <= PS_WAIT;
      tmr_q     <= TMR_RELOAD;
      stat_q    <= '0;
      ls_q      <= LS_DOWN;
      good_q    <= '0;
      bad_q     <= '0;
      sticky_q  <= '0;
      mask_q    <= '0;
      poll_en_q <= 1'b1;
    end else begin
      ps_q      <= ps_d;
      tmr_q     <= tmr_d;
      stat_q    <= stat_d;
      ls_q      <= ls_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      sticky_q  <= sticky_d;
      mask_q    <= mask_d;
      poll_en_q <= poll_en_d;
    end
  end

  fc_sat_counter #(.CNT_W(CNT_W)) u_los_cnt (
    .mgmt_clk (mgmt_clk),
    .reset    (reset),
    .inc_i    (los_inc),
    .clr_i    (wr_los),
    .value_o  (los_val)
  );

  fc_sat_counter #(.CNT_W(CNT_W)) u_cerr_cnt (
    .mgmt_clk (mgmt_clk),
    .reset    (reset),
    .inc_i    (cerr_inc),
    .clr_i    (wr_cerr),
    .value_o  (cerr_val)
  );

`ifdef FC_LINK_MON_UNKNOWN_PRIM_EN
  assign wr_unk = csr_write && (csr_address == CSR_UNK_CNT);

  // last distinct unknown-primitive word
  always_ff @(posedge mgmt_clk) begin
    if (reset) unk_word_q <= '0;
    else       unk_word_q <= unk_word_d;
  end

  fc_sat_counter #(.CNT_W(CNT_W)) u_unk_cnt (
    .mgmt_clk (mgmt_clk),
    .reset    (reset),
    .inc_i    (unk_new),
    .clr_i    (wr_unk),
    .value_o  (unk_val)
  );
`endif

  // CSR read mux, zero wait state
  always_comb begin
    rdata = '0;
    case (csr_address)
      CSR_STATUS: rdata = {14'b0, ls_q, stat_q[15:0]};
      CSR_LOS:    rdata = 32'(los_val);
      CSR_CERR:   rdata = 32'(cerr_val);
      CSR_STICKY: rdata = 32'(sticky_q);
      CSR_CTRL: begin
        rdata[0]            = poll_en_q;
        rdata[8 +: STICKY_W] = mask_q;
      end
`ifdef FC_LINK_MON_UNKNOWN_PRIM_EN
      CSR_UNK_WORD: rdata = unk_word_q;
      CSR_UNK_CNT:  rdata = 32'(unk_val);
`endif
      default: rdata = '0;
    endcase
  end

  assign csr_readdata = csr_read ? rdata : '0;

`ifdef FC_LINK_MON_UNKNOWN_PRIM_EN
  assign xm_read    = (ps_q == PS_RD_STATUS) || (ps_q == PS_RD_UNKNOWN);
  assign xm_address = (ps_q == PS_RD_UNKNOWN) ? ADDR_UNKNOWN : ADDR_STATUS;
`else
  assign xm_read    = (ps_q == PS_RD_STATUS);
  assign xm_address = ADDR_STATUS;
`endif

  assign link_up = (ls_q == LS_UP);
  assign irq     = |(sticky_q & mask_q);

endmodule
